// File: rtl/femto8_pkg.sv
// Shared definitions for the femto8 bus responder: address map, status bits, loader states.
package femto8_pkg;

   localparam logic [7:0] ROM_BASE  = 8'h80;
   localparam logic [7:0] OUT_ADDR  = 8'h0F;
   localparam logic [7:0] STAT_ADDR = 8'h0E;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_OVF   = 2;

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } load_state_t;

endpackage

// File: rtl/femto8_byte_fifo.sv
// Byte FIFO with occupancy count; a push into a full FIFO is accepted only alongside a pop.
module femto8_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               din,
   output logic                     full,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap on their own because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/femto8_bus_responder.sv
// femto8 memory-side responder: ROM loader that holds the CPU in reset, RAM, and a memory-mapped output FIFO.
module femto8_bus_responder #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] OUT_ADDR   = femto8_pkg::OUT_ADDR,
   parameter logic [7:0] STAT_ADDR  = femto8_pkg::STAT_ADDR
) (
   input  logic       clk,
   input  logic       reset,
   output logic       cpu_reset,
   input  logic [7:0] address,
   input  logic [7:0] cpu_wdata,
   input  logic       write,
   output logic [7:0] cpu_rdata,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   input  logic       ld_last,
   output logic       ld_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       loaded
);

   import femto8_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   load_state_t   state;
   logic [6:0]    ptr;
   logic          overflow;
   logic [7:0]    rom [128];
   logic [7:0]    ram [128];

   logic          ld_accept;
   logic          cpu_we;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          ram_we;
   logic          is_rom;

   assign is_rom    = address[7];
   assign ld_accept = ld_valid && ld_ready;
   assign cpu_we    = write && (state == S_RUN);
   assign fifo_push = cpu_we && (address == OUT_ADDR);
   assign fifo_pop  = out_ready && out_valid;
   assign ram_we    = cpu_we && !is_rom && (address != OUT_ADDR) && (address != STAT_ADDR);
   assign out_valid = !fifo_empty;

   femto8_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (cpu_wdata),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .dout  (out_data),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Loader FSM; outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LOAD;
         cpu_reset <= 1'b1;
         ld_ready  <= 1'b1;
         loaded    <= 1'b0;
         ptr       <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (ld_accept) begin
                  if (ptr != 7'd127) ptr <= ptr + 7'd1;
                  if (ld_last || ptr == 7'd127) begin
                     state     <= S_RUN;
                     cpu_reset <= 1'b0;
                     ld_ready  <= 1'b0;
                     loaded    <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               state <= S_RUN;
            end
            default: begin
               state     <= S_LOAD;
               cpu_reset <= 1'b1;
               ld_ready  <= 1'b1;
               loaded    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ld_accept) rom[ptr] <= ld_data;
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram[address[6:0]] <= cpu_wdata;
   end

   // A full FIFO with a pop in the same cycle still takes the push, so no overflow then.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (fifo_push && fifo_full && !fifo_pop) begin
         overflow <= 1'b1;
      end else if (cpu_we && address == STAT_ADDR) begin
         overflow <= 1'b0;
      end
   end

   always_comb begin
      cpu_rdata = ram[address[6:0]];
      if (is_rom) begin
         cpu_rdata = rom[address[6:0]];
      end else if (address == STAT_ADDR) begin
         cpu_rdata           = 8'h00;
         cpu_rdata[ST_FULL]  = fifo_full;
         cpu_rdata[ST_EMPTY] = fifo_empty;
         cpu_rdata[ST_OVF]   = overflow;
      end else if (address == OUT_ADDR) begin
         cpu_rdata = 8'(fifo_count);
      end
   end

endmodule

// File: tb/tb_femto8_bus_responder.sv
// Directed bench for femto8_bus_responder: loader, RAM/ROM bus, and output FIFO with a scoreboard queue.
module tb_femto8_bus_responder;

   logic       clk;
   logic       reset;
   logic       cpu_reset;
   logic [7:0] address;
   logic [7:0] cpu_wdata;
   logic       write;
   logic [7:0] cpu_rdata;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_last;
   logic       ld_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       loaded;

   logic [7:0] exp_q[$];
   int         compared;
   int         mismatched;

   femto8_bus_responder #(
      .FIFO_DEPTH (4),
      .OUT_ADDR   (8'h0F),
      .STAT_ADDR  (8'h0E)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_reset (cpu_reset),
      .address   (address),
      .cpu_wdata (cpu_wdata),
      .write     (write),
      .cpu_rdata (cpu_rdata),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_last   (ld_last),
      .ld_ready  (ld_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .loaded    (loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
      end
   endtask

   // Compare the FIFO head against the scoreboard whenever the coming edge pops it.
   task automatic sample_pop();
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL fifo_pop: observed %02h expected nothing", out_data);
         end else begin
            check("fifo_pop", out_data, exp_q.pop_front());
         end
      end
   endtask

   task automatic tick();
      sample_pop();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      ld_valid  = 1'b0;
      ld_last   = 1'b0;
      write     = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] expv, input string tag);
      address = a;
      #1;
      check(tag, cpu_rdata, expv);
   endtask

   task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
      address   = a;
      cpu_wdata = d;
      write     = 1'b1;
      tick();
      write = 1'b0;
   endtask

   task automatic load_byte(input logic [7:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      check("ld_ready_load", {7'b0, ld_ready}, 8'h01);
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
      out_ready = 1'b0;
      check("drain_left", 8'(exp_q.size()), 8'h00);
   endtask

   initial begin
      logic [7:0] prog [6];
      prog[0] = 8'h10; prog[1] = 8'h01; prog[2] = 8'h5C;
      prog[3] = 8'h81; prog[4] = 8'hA7; prog[5] = 8'h82;
      compared   = 0;
      mismatched = 0;
      address    = 8'h00;
      cpu_wdata  = 8'h00;
      ld_data    = 8'h00;
      @(negedge clk);
      do_reset();

      // Reset state
      check("rst_cpu_reset", {7'b0, cpu_reset}, 8'h01);
      check("rst_ld_ready", {7'b0, ld_ready}, 8'h01);
      check("rst_loaded", {7'b0, loaded}, 8'h00);
      check("rst_out_valid", {7'b0, out_valid}, 8'h00);
      rd(8'h0E, 8'h02, "rst_status");
      rd(8'h0F, 8'h00, "rst_count");

      // Six-byte program, last flagged
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            check("pre_last_cpu_reset", {7'b0, cpu_reset}, 8'h01);
            check("pre_last_loaded", {7'b0, loaded}, 8'h00);
         end
         load_byte(prog[i], i == 5);
      end
      check("run_cpu_reset", {7'b0, cpu_reset}, 8'h00);
      check("run_loaded", {7'b0, loaded}, 8'h01);
      check("run_ld_ready", {7'b0, ld_ready}, 8'h00);
      for (int i = 0; i < 6; i++) rd(8'h80 + 8'(i), prog[i], "rom_prog");
      ld_valid = 1'b1;
      ld_data  = 8'hEE;
      tick();
      ld_valid = 1'b0;
      rd(8'h80, 8'h10, "rom_after_extra_ld");
      check("extra_ld_loaded", {7'b0, loaded}, 8'h01);

      // RAM write/read, ROM write ignored
      cpu_wr(8'h05, 8'h3C);
      rd(8'h05, 8'h3C, "ram_rw");
      cpu_wr(8'h85, 8'hEE);
      rd(8'h85, 8'h82, "rom_readonly");

      // Fill and overflow
      for (int i = 0; i < 5; i++) begin
         cpu_wr(8'h0F, 8'hA1 + 8'(i));
         if (i < 4) exp_q.push_back(8'hA1 + 8'(i));
         if (i == 3) rd(8'h0E, 8'h01, "status_full");
         if (i == 4) rd(8'h0E, 8'h05, "status_full_ovf");
      end
      rd(8'h0F, 8'h04, "count_full");
      check("out_valid_full", {7'b0, out_valid}, 8'h01);
      cpu_wr(8'h0E, 8'hFF);
      rd(8'h0E, 8'h01, "status_ovf_clr");
      drain();
      rd(8'h0E, 8'h02, "status_drained");

      // Push and pop together when full
      for (int i = 0; i < 4; i++) begin
         cpu_wr(8'h0F, 8'hC1 + 8'(i));
         exp_q.push_back(8'hC1 + 8'(i));
      end
      exp_q.push_back(8'hB0);
      out_ready = 1'b1;
      cpu_wr(8'h0F, 8'hB0);
      out_ready = 1'b0;
      rd(8'h0F, 8'h04, "count_push_pop_full");
      rd(8'h0E, 8'h01, "status_push_pop_full");
      drain();
      rd(8'h0E, 8'h02, "status_drained2");

      // Reset mid-load; CPU writes ignored while loading
      do_reset();
      load_byte(8'h11, 1'b0);
      load_byte(8'h22, 1'b0);
      load_byte(8'h33, 1'b0);
      cpu_wr(8'h05, 8'h99);
      cpu_wr(8'h0F, 8'h77);
      rd(8'h0E, 8'h02, "status_load_write");
      do_reset();
      check("midrst_cpu_reset", {7'b0, cpu_reset}, 8'h01);
      check("midrst_ld_ready", {7'b0, ld_ready}, 8'h01);
      load_byte(8'h44, 1'b1);
      rd(8'h80, 8'h44, "midrst_rom0");
      rd(8'h81, 8'h22, "midrst_rom1");
      rd(8'h83, 8'h81, "midrst_rom3");
      rd(8'h05, 8'h3C, "ram_load_ignored");
      check("midrst_out_valid", {7'b0, out_valid}, 8'h00);

      // Full 128-byte image without ld_last
      do_reset();
      for (int i = 0; i < 128; i++) begin
         if (i == 127) check("pre128_loaded", {7'b0, loaded}, 8'h00);
         load_byte(8'(i) ^ 8'h5A, 1'b0);
      end
      check("full_loaded", {7'b0, loaded}, 8'h01);
      check("full_ld_ready", {7'b0, ld_ready}, 8'h00);
      check("full_cpu_reset", {7'b0, cpu_reset}, 8'h00);
      ld_valid = 1'b1;
      ld_data  = 8'h00;
      tick();
      ld_valid = 1'b0;
      rd(8'h80, 8'h5A, "full_rom0");
      rd(8'hC0, 8'h1A, "full_rom64");
      rd(8'hFF, 8'h25, "full_rom127");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
